// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// State enum, opcode constants, immediate-format and ALU-op codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    // R-type has no immediate; IMM_I is a harmless don't-care there.
    function automatic logic [1:0] imm_sel_of(input cls_t cls);
        case (cls)
            CLS_STORE:  return IMM_S;
            CLS_BRANCH: return IMM_B;
            default:    return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: instruction class plus illegal flag.
// BRANCH is only recognised when MULTICYCLE_CTRL_BRANCH_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output cls_t       cls_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = CLS_R;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R:      cls_o = CLS_R;
            OP_IALU:   cls_o = CLS_I;
            OP_LOAD:   cls_o = CLS_LOAD;
            OP_STORE:  cls_o = CLS_STORE;
`ifdef MULTICYCLE_CTRL_BRANCH_EN
            OP_BRANCH: cls_o = CLS_BRANCH;
`endif
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with retire counter and sticky illegal trap.
// Optional branch support is enabled by defining MULTICYCLE_CTRL_BRANCH_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             mem_ready_i,
    input  logic             zero_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_branch_o,
    output logic [1:0]       imm_sel_o,
    output logic             alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_instret;

    cls_t w_cls;
    logic w_illegal;
    logic w_fetch_done;
    logic w_mem_done;
    logic w_is_branch;
    logic w_retire;
    logic w_unused_instr;

    // IR is stable from ID onward, so decoding it live is safe in every later state.
    ctrl_decode u_decode (
        .opcode_i  (instr_i[6:0]),
        .cls_o     (w_cls),
        .illegal_o (w_illegal)
    );

    assign w_unused_instr = ^instr_i[31:7];

`ifdef MULTICYCLE_CTRL_BRANCH_EN
    assign w_is_branch = (w_cls == CLS_BRANCH);
    assign pc_branch_o = !rst_i && (r_state == ST_EX) && w_is_branch && zero_i;
`else
    assign w_is_branch = 1'b0;
    assign pc_branch_o = 1'b0;
`endif

    assign w_fetch_done = !rst_i && (r_state == ST_IF)  && mem_ready_i;
    assign w_mem_done   = !rst_i && (r_state == ST_MEM) && mem_ready_i;
    assign w_retire     = !rst_i && (((r_state == ST_EX) && w_is_branch) ||
                                     (w_mem_done && (w_cls == CLS_STORE)) ||
                                     (r_state == ST_WB));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IF;
            r_instret <= '0;
        end else begin
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
            case (r_state)
                ST_IF:   if (mem_ready_i) r_state <= ST_ID;
                ST_ID:   r_state <= w_illegal ? ST_TRAP : ST_EX;
                ST_EX: begin
                    case (w_cls)
                        CLS_BRANCH:          r_state <= ST_IF;
                        CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
                        default:             r_state <= ST_WB;
                    endcase
                end
                ST_MEM:  if (mem_ready_i) r_state <= (w_cls == CLS_STORE) ? ST_IF : ST_WB;
                ST_WB:   r_state <= ST_IF;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_IF;
            endcase
        end
    end

    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        imm_sel_o    = IMM_I;
        alu_src_b_o  = 1'b0;
        alu_op_o     = ALU_ADD;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;
        case (r_state)
            ST_IF: begin
                mem_req_o  = 1'b1;
                ir_write_o = w_fetch_done;
                pc_write_o = w_fetch_done;
            end
            ST_ID: imm_sel_o = imm_sel_of(w_cls);
            ST_EX: begin
                imm_sel_o = imm_sel_of(w_cls);
                case (w_cls)
                    CLS_R:               alu_op_o = ALU_FUNCT;
                    CLS_I: begin
                        alu_src_b_o = 1'b1;
                        alu_op_o    = ALU_FUNCT;
                    end
                    CLS_LOAD, CLS_STORE: alu_src_b_o = 1'b1;
                    CLS_BRANCH:          alu_op_o = ALU_SUB;
                    default:             alu_op_o = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                imm_sel_o = imm_sel_of(w_cls);
                mem_req_o = 1'b1;
                mem_we_o  = (w_cls == CLS_STORE);
            end
            ST_WB: begin
                reg_write_o  = !rst_i;
                mem_to_reg_o = (w_cls == CLS_LOAD);
            end
            ST_TRAP: illegal_o = 1'b1;
            default: illegal_o = 1'b0;
        endcase
    end

    assign instret_o = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed literal cases then randomized traffic,
// all checked every cycle against a per-instruction stage-plan model.
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] instr_i = 32'h0000_0013;
    logic        mem_ready_i = 1'b0;
    logic        zero_i = 1'b0;
    logic        mem_req_o, mem_we_o, ir_write_o, pc_write_o, pc_branch_o;
    logic [1:0]  imm_sel_o, alu_op_o;
    logic        alu_src_b_o, reg_write_o, mem_to_reg_o, illegal_o;
    logic [63:0] instret_o;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .mem_ready_i(mem_ready_i),
        .zero_i(zero_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_branch_o(pc_branch_o),
        .imm_sel_o(imm_sel_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o),
        .instret_o(instret_o)
    );

`ifdef MULTICYCLE_CTRL_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       req, we, irw, pcw, pcb;
        logic [1:0] imm;
        logic       srcb;
        logic [1:0] op;
        logic       rw, m2r, ill;
    } obs_t;

    int          checks = 0;
    int          failures = 0;
    string       plan = "F";
    int          pos = 0;
    logic [31:0] ir = 32'h0000_0013;
    logic [31:0] fetch_word = 32'h0000_0013;
    logic [63:0] m_cnt = '0;
    obs_t        snap;
    logic [63:0] snap_cnt;

    // Stage letters: F fetch, D decode, X execute, M memory, W write-back, T trap.
    function automatic string plan_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011: return "FDXW";
            7'b0000011:             return "FDXMW";
            7'b0100011:             return "FDXM";
            7'b1100011:             return BR_EN ? "FDX" : "FDT";
            default:                return "FDT";
        endcase
    endfunction

    function automatic obs_t expect_obs(input byte stg, input logic [31:0] w,
                                        input logic rdy, input logic z, input logic r);
        obs_t       e;
        logic [6:0] op;
        logic       is_ld, is_st, is_br, is_r, is_i;
        logic [1:0] imm;
        e     = '0;
        op    = w[6:0];
        is_r  = (op == 7'b0110011);
        is_i  = (op == 7'b0010011);
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        is_br = (op == 7'b1100011) && BR_EN;
        imm   = is_st ? 2'd1 : (is_br ? 2'd2 : 2'd0);
        if (stg == "F") begin
            e.req = 1'b1; e.irw = rdy; e.pcw = rdy;
        end else if (stg == "D") begin
            e.imm = imm;
        end else if (stg == "X") begin
            e.imm = imm;
            if (is_r || is_i) begin
                e.srcb = is_i; e.op = 2'd2;
            end else if (is_ld || is_st) begin
                e.srcb = 1'b1; e.op = 2'd0;
            end else if (is_br) begin
                e.op = 2'd1; e.pcb = z;
            end
        end else if (stg == "M") begin
            e.req = 1'b1; e.we = is_st; e.imm = imm;
        end else if (stg == "W") begin
            e.rw = 1'b1; e.m2r = is_ld;
        end else if (stg == "T") begin
            e.ill = 1'b1;
        end
        if (r) begin
            e.irw = 1'b0; e.pcw = 1'b0; e.pcb = 1'b0; e.rw = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance the model on posedge.
    task automatic step(input logic r, input logic rdy, input logic z);
        obs_t a, e;
        byte  stg;
        rst_i = r; mem_ready_i = rdy; zero_i = z;
        @(negedge clk_i);
        stg = plan[pos];
        e = expect_obs(stg, ir, rdy, z, r);
        a.req = mem_req_o;   a.we = mem_we_o;     a.irw = ir_write_o; a.pcw = pc_write_o;
        a.pcb = pc_branch_o; a.imm = imm_sel_o;   a.srcb = alu_src_b_o; a.op = alu_op_o;
        a.rw = reg_write_o;  a.m2r = mem_to_reg_o; a.ill = illegal_o;
        snap = a; snap_cnt = instret_o;
        chk("outputs", 64'(a), 64'(e));
        chk("instret", instret_o, m_cnt);
        @(posedge clk_i);
        if (r) begin
            plan = "F"; pos = 0; m_cnt = '0;
        end else if (stg != "T" && !((stg == "F" || stg == "M") && !rdy)) begin
            if (stg == "F") begin
                ir = fetch_word;
                plan = plan_of(fetch_word);
            end
            pos++;
            if (pos == plan.len()) begin
                m_cnt = m_cnt + 64'd1;
                plan = "F"; pos = 0;
            end
        end
        #1;
        instr_i = ir;
    endtask

    task automatic run_ready(input logic [31:0] w, input int n, input logic z);
        fetch_word = w;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, z);
    endtask

    logic [31:0] rw_word;
    int          pick;
    logic        any_rw;
    logic        r_rand;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        chk("rst_mem_req", 64'(snap.req), 64'd1);
        chk("rst_instret", snap_cnt, 64'd0);
        chk("rst_illegal", 64'(snap.ill), 64'd0);
        chk("rst_imm_sel", 64'(snap.imm), 64'd0);

        // ADDI x1,x0,5
        run_ready(32'h0050_0093, 3, 1'b0);
        chk("addi_src_b", 64'(snap.srcb), 64'd1);
        chk("addi_imm_sel", 64'(snap.imm), 64'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("addi_reg_write_c4", 64'(snap.rw), 64'd1);
        chk("addi_instret", instret_o, 64'd1);

        // SW with three stall cycles in MEM
        run_ready(32'h0011_2023, 3, 1'b0);
        any_rw = snap.rw;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("sw_we_held", 64'({snap.req, snap.we}), 64'd3);
            any_rw |= snap.rw;
        end
        step(1'b0, 1'b1, 1'b0);
        any_rw |= snap.rw;
        chk("sw_no_reg_write", 64'(any_rw), 64'd0);
        chk("sw_instret", instret_o, 64'd2);

        // LW x1,0(x2)
        run_ready(32'h0001_2083, 5, 1'b0);
        chk("lw_wb", 64'({snap.rw, snap.m2r}), 64'd3);
        chk("lw_instret", instret_o, 64'd3);

        // BEQ x0,x0,0 taken then not taken
        run_ready(32'h0000_0063, 3, 1'b1);
        if (BR_EN) begin
            chk("beq_taken_pcb", 64'({snap.pcb, snap.imm}), 64'b110);
            run_ready(32'h0000_0063, 3, 1'b0);
            chk("beq_not_taken_pcb", 64'({snap.pcb, snap.imm}), 64'b010);
            chk("beq_instret", instret_o, 64'd5);
        end else begin
            chk("beq_illegal", 64'(snap.ill), 64'd1);
        end
        step(1'b1, 1'b0, 1'b0);

        // Illegal opcode traps; reset recovers
        run_ready(32'h0000_007F, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("trap_state", 64'({snap.req, snap.ill}), 64'b01);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("trap_cleared", 64'({snap.req, snap.ill}), 64'b10);

        // Counter wrap
        force dut.r_instret = '1;
        m_cnt = '1;
        step(1'b0, 1'b0, 1'b0);
        release dut.r_instret;
        run_ready(32'h0050_0093, 4, 1'b0);
        chk("instret_wrap", instret_o, 64'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            pick = $urandom_range(0, 9);
            rw_word = $urandom();
            case (pick)
                0, 1:    rw_word[6:0] = 7'b0110011;
                2, 3:    rw_word[6:0] = 7'b0010011;
                4, 5:    rw_word[6:0] = 7'b0000011;
                6, 7:    rw_word[6:0] = 7'b0100011;
                8:       rw_word[6:0] = 7'b1100011;
                default: rw_word[6:0] = rw_word[6:0];
            endcase
            if (plan[pos] == "F") fetch_word = rw_word;
            r_rand = ($urandom_range(0, 199) == 0) ||
                     ((plan[pos] == "T") && ($urandom_range(0, 5) == 0));
            step(r_rand, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
